// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
// ram_responder : RAM-side responder for the cache-to-RAM word protocol.
// Rev 1.0
// ============================================================================
module ram_responder #(
    parameter int ADDR_SIZE   = 13,
    parameter int WORD_SIZE   = 16,
    parameter int LATENCY     = 4,
    parameter int QUEUE_DEPTH = 4,
    parameter int ACK_WRITES  = 0
) (
    input  logic                 ram_clk,
    input  logic                 ram_rst_n,
    input  logic [ADDR_SIZE-1:0] ram_addr,
    input  logic [WORD_SIZE-1:0] ram_wdata,
    input  logic                 ram_avalid,
    input  logic                 ram_rnw,
    output logic [WORD_SIZE-1:0] ram_rdata,
    output logic                 ram_ack,
    output logic                 busy,
    output logic                 overflow
);

    localparam int       c_QW        = $clog2(QUEUE_DEPTH);
    localparam int       c_PW        = c_QW + 1;
    // The IDLE pop edge already counts as one cycle of the access, so the
    // first load is one shorter than the back-to-back reload.
    localparam logic [3:0] c_CNT_FIRST = 4'(LATENCY - 2);
    localparam logic [3:0] c_CNT_NEXT  = 4'(LATENCY - 1);
    localparam logic       c_ACK_WR    = (ACK_WRITES != 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_cnt;
    logic [3:0]             w_cnt_nxt;
    logic                   w_pop;
    logic                   w_done;

    logic                   r_q_rnw   [QUEUE_DEPTH];
    logic [ADDR_SIZE-1:0]   r_q_addr  [QUEUE_DEPTH];
    logic [WORD_SIZE-1:0]   r_q_wdata [QUEUE_DEPTH];
    logic [c_PW-1:0]        r_wr_ptr;
    logic [c_PW-1:0]        r_rd_ptr;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_req;
    logic                   w_push;

    logic                   r_svc_rnw;
    logic [ADDR_SIZE-1:0]   r_svc_addr;
    logic [WORD_SIZE-1:0]   r_svc_wdata;

    logic [WORD_SIZE-1:0]   r_mem [2**ADDR_SIZE];
    logic [WORD_SIZE-1:0]   w_mem_rd;

    logic                   r_live;
    logic                   r_ack;
    logic [WORD_SIZE-1:0]   r_rdata;
    logic                   r_overflow;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_QW] != r_rd_ptr[c_QW]) &&
                     (r_wr_ptr[c_QW-1:0] == r_rd_ptr[c_QW-1:0]);

    // r_live masks the first edge after reset release.
    assign w_req   = ram_avalid && r_live;
    assign w_push  = w_req && (!w_full || w_pop);

    assign w_mem_rd = r_mem[r_svc_addr];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = c_CNT_FIRST;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_done = 1'b1;
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_cnt_nxt = c_CNT_NEXT;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_live      <= 1'b0;
            r_overflow  <= 1'b0;
            r_ack       <= 1'b0;
            r_rdata     <= '0;
            r_svc_rnw   <= 1'b0;
            r_svc_addr  <= '0;
            r_svc_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_live  <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_svc_rnw   <= r_q_rnw[r_rd_ptr[c_QW-1:0]];
                r_svc_addr  <= r_q_addr[r_rd_ptr[c_QW-1:0]];
                r_svc_wdata <= r_q_wdata[r_rd_ptr[c_QW-1:0]];
            end
            if (w_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            r_ack   <= w_done && (r_svc_rnw || c_ACK_WR);
            r_rdata <= (w_done && r_svc_rnw) ? w_mem_rd : '0;
        end
    end

    always_ff @(posedge ram_clk) begin
        if (w_push) begin
            r_q_rnw[r_wr_ptr[c_QW-1:0]]   <= ram_rnw;
            r_q_addr[r_wr_ptr[c_QW-1:0]]  <= ram_addr;
            r_q_wdata[r_wr_ptr[c_QW-1:0]] <= ram_wdata;
        end
    end

    // Backing array is deliberately not reset.
    always_ff @(posedge ram_clk) begin
        if (w_done && !r_svc_rnw) begin
            r_mem[r_svc_addr] <= r_svc_wdata;
        end
    end

    assign ram_ack   = r_ack;
    assign ram_rdata = r_rdata;
    assign overflow  = r_overflow;
    assign busy      = !w_empty || (r_state == S_BUSY);

endmodule
`default_nettype wire
